// File: rtl/fifo_switch_tester_pkg.sv
// Shared constants for the switch-driven FIFO exerciser.
// Defaults for word width, address width and debounce length.
package fifo_switch_tester_pkg;
  localparam int DATA_W_DEF    = 2;
  localparam int ADDR_W_DEF    = 2;
  localparam int DB_CYCLES_DEF = 4;
  localparam int DEPTH_DEF     = 1 << ADDR_W_DEF;
endpackage

// File: rtl/switch_debouncer.sv
// Counter debouncer for one clk-synchronous switch.
// Emits a registered one-cycle tick on each debounced press.
module switch_debouncer
  import fifo_switch_tester_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic tick
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      db   <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (raw == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt  <= '0;
        db   <= raw;
        tick <= raw;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/fifo_switch_tester.sv
// Board exerciser: debounced switches push/pop a small FIFO,
// LEDs show head word, occupancy and status.
module fifo_switch_tester
  import fifo_switch_tester_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw0,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic db_sw0,
  output logic db_sw1,
  output logic sw0_tick,
  output logic sw1_tick
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              empty;
  logic              full;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] head;

  switch_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .clk  (clk),
    .reset(reset),
    .raw  (sw0),
    .db   (db_sw0),
    .tick (sw0_tick)
  );

  switch_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .clk  (clk),
    .reset(reset),
    .raw  (sw1),
    .db   (db_sw1),
    .tick (sw1_tick)
  );

  assign wdata = {sw3, sw2};
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_en = sw0_tick && !empty;
  // A full FIFO still accepts a write when a read frees a slot.
  assign wr_en = sw1_tick && (!full || rd_en);
  assign head  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (rd_en) begin
        rptr <= rptr + ADDR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - CNT_W'(1);
      end
      if (sw1_tick && !wr_en) begin
        ovf <= 1'b1;
      end
    end
  end

  assign led0 = head[0];
  assign led1 = head[1];
  assign led2 = count[0];
  assign led3 = count[1];
  assign led4 = count[2];
  assign led5 = ovf;
  assign led6 = empty;
  assign led7 = full;
endmodule

// File: tb/tb_fifo_switch_tester.sv
// Directed bench for fifo_switch_tester with a queue-based
// reference FIFO compared against the LED outputs.
module tb_fifo_switch_tester;
  logic clk = 1'b0;
  logic reset;
  logic sw0, sw1, sw2, sw3;
  logic led0, led1, led2, led3, led4, led5, led6, led7;
  logic db_sw0, db_sw1, sw0_tick, sw1_tick;

  int checks = 0;
  int errors = 0;
  logic [1:0] model_q[$];
  logic exp_ovf = 1'b0;

  always #5 clk = ~clk;

  fifo_switch_tester dut (
    .clk     (clk),
    .reset   (reset),
    .sw0     (sw0),
    .sw1     (sw1),
    .sw2     (sw2),
    .sw3     (sw3),
    .led0    (led0),
    .led1    (led1),
    .led2    (led2),
    .led3    (led3),
    .led4    (led4),
    .led5    (led5),
    .led6    (led6),
    .led7    (led7),
    .db_sw0  (db_sw0),
    .db_sw1  (db_sw1),
    .sw0_tick(sw0_tick),
    .sw1_tick(sw1_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_leds(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    logic [2:0] n;
    logic [1:0] h;
    n = 3'(model_q.size());
    h = (model_q.size() == 0) ? 2'b00 : model_q[0];
    exp = {(n == 3'd4), (n == 3'd0), exp_ovf, n, h};
    obs = {led7, led6, led5, led4, led3, led2, led1, led0};
    chk(tag, {24'd0, obs}, {24'd0, exp});
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
    model_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Press and release switches; the reference model updates on the tick.
  task automatic press(input string tag, input bit rd, input bit wr,
                       input logic [1:0] data);
    int wait_n;
    int tick_n;
    bit was_empty;
    {sw3, sw2} = data;
    sw0 = rd;
    sw1 = wr;
    wait_n = 0;
    while (!((rd && sw0_tick) || (wr && sw1_tick)) && wait_n < 12) begin
      step();
      wait_n++;
    end
    if (wait_n >= 12) chk({tag, "_tick_timeout"}, 0, 1);
    was_empty = (model_q.size() == 0);
    if (rd && !was_empty) void'(model_q.pop_front());
    if (wr) begin
      if (model_q.size() < 4) model_q.push_back(data);
      else exp_ovf = 1'b1;
    end
    step();
    chk({tag, "_tick_once"}, {30'd0, sw1_tick, sw0_tick}, 0);
    chk_leds(tag);
    sw0 = 1'b0;
    sw1 = 1'b0;
    tick_n = 0;
    repeat (6) begin
      step();
      tick_n += int'(sw0_tick) + int'(sw1_tick);
    end
    chk({tag, "_no_release_tick"}, tick_n, 0);
  endtask

  initial begin
    int rise_at;
    int tick_n;
    {sw0, sw1, sw2, sw3} = 4'b0000;
    reset = 1'b1;
    do_reset(3);
    chk_leds("reset_leds");
    chk("reset_db_tick", {28'd0, db_sw1, db_sw0, sw1_tick, sw0_tick}, 0);

    sw1 = 1'b1;
    repeat (2) step();
    sw1 = 1'b0;
    tick_n = 0;
    repeat (6) begin
      step();
      tick_n += int'(sw1_tick) + int'(db_sw1);
    end
    chk("glitch_ignored", tick_n, 0);

    sw1 = 1'b1;
    rise_at = -1;
    tick_n = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (db_sw1 && rise_at < 0) rise_at = i;
      tick_n += int'(sw1_tick);
    end
    chk("db_rise_edge", rise_at, 4);
    chk("tick_one_cycle", tick_n, 1);
    sw1 = 1'b0;
    repeat (6) step();

    sw1 = 1'b1;
    repeat (2) step();
    do_reset(1);
    repeat (3) step();
    chk("reset_clears_debounce", {31'd0, db_sw1}, 0);
    chk_leds("reset_mid_op");
    sw1 = 1'b0;
    repeat (6) step();

    press("fill0", 0, 1, 2'b00);
    press("fill1", 0, 1, 2'b01);
    press("fill2", 0, 1, 2'b10);
    press("fill3", 0, 1, 2'b11);
    chk("full_led7", {31'd0, led7}, 1);
    press("overflow", 0, 1, 2'b11);
    chk("overflow_led5", {31'd0, led5}, 1);

    press("drain0", 1, 0, 2'b00);
    press("drain1", 1, 0, 2'b00);
    press("drain2", 1, 0, 2'b00);
    press("drain3", 1, 0, 2'b00);
    chk("drained_empty", {31'd0, led6}, 1);

    press("read_empty", 1, 0, 2'b00);
    press("simul_empty", 1, 1, 2'b10);
    press("simul_mid", 1, 1, 2'b01);
    press("fill_b1", 0, 1, 2'b11);
    press("fill_b2", 0, 1, 2'b00);
    press("fill_b3", 0, 1, 2'b10);
    press("simul_full", 1, 1, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_switch_tester.md
Name: fifo_switch_tester

Overview:
- Board-level exerciser for a small synchronous FIFO.
- Two debounced push switches drive it: sw1 writes, sw0 reads. Two data switches (sw3, sw2) supply the 2-bit write word.
- LEDs show the FIFO head word, occupancy, empty, full and overflow status.
- Debounced levels and one-cycle ticks are exported for visibility.

Parameters:
- DATA_W, 2, FIFO word width; write data is {sw3,sw2}.
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W = 4 entries.
- DB_CYCLES, 4, consecutive stable samples required before a debounced level changes.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- sw0  in  1  raw read switch.
- sw1  in  1  raw write switch.
- sw2  in  1  write data bit 0.
- sw3  in  1  write data bit 1.
- led0  out  1  head word bit 0.
- led1  out  1  head word bit 1.
- led2  out  1  occupancy bit 0.
- led3  out  1  occupancy bit 1.
- led4  out  1  occupancy bit 2.
- led5  out  1  sticky overflow flag.
- led6  out  1  empty.
- led7  out  1  full.
- db_sw0  out  1  debounced sw0.
- db_sw1  out  1  debounced sw1.
- sw0_tick  out  1  one-cycle pulse on db_sw0 rising.
- sw1_tick  out  1  one-cycle pulse on db_sw1 rising.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset=0 resets on the next rising clk edge).
- Reset values:
  - all pointers, occupancy, overflow, db_* and *_tick are 0.
  - Storage contents are don't-care; head LEDs read 0.
  - led6=1, led7=0.
- Debounce, per switch, with no synchronizer (inputs are clk-synchronous):
  - A counter increments each edge the raw input differs from db.
  - It clears on any edge the raw input equals db.
  - On the edge the count reaches DB_CYCLES, db takes the raw value and the counter clears.
  - Glitches shorter than DB_CYCLES are ignored.
- Tick:
  - Registered; set on the same edge db goes 0->1, cleared on the next edge.
  - Exactly one cycle per press; no tick on release.
- Write:
  - On an edge where sw1_tick=1 and not full: mem[wptr] <= {sw3,sw2}, sampled at that edge; wptr increments.
  - When full, the write is dropped and led5 is set; led5 stays set until reset.
- Read:
  - On an edge where sw0_tick=1 and not empty, rptr increments.
  - When empty, the read is ignored with no flag.
- Simultaneous read and write ticks:
  - Not empty and not full: both occur; occupancy unchanged.
  - Empty: write only.
  - Full: both occur; no overflow.
- Head word: led1:led0 = mem[rptr] (first-word fall-through), forced to 00 while empty.
- Occupancy:
  - led4:led2 = count, range 0..4.
  - empty = (count==0); full = (count==4).
  - Pointers wrap modulo 4.
- Latency: LED/status updates appear one edge after the tick cycle.
- Reset mid-operation: clears everything on that edge, including an in-progress debounce count.

Decomposition:
- Shared package: DATA_W, ADDR_W and DB_CYCLES defaults; FIFO depth constant.
- One sub-module: switch_debouncer, with ports clk, reset, raw, db, tick, instantiated for sw0 and sw1.
- FIFO storage, pointers, count and LED mapping live inline in fifo_switch_tester.

Test Plan:
- Reset: hold reset=0 for 3 edges -> led6=1; led7, led5 = 0; led4:2=000; led1:0=00; db_*=0; ticks=0.
- Debounce: sw1 glitch of 2 cycles -> db_sw1 and sw1_tick stay 0. Hold sw1=1 for 15 cycles -> db_sw1 rises after 4 edges; sw1_tick high for exactly 1 cycle.
- Fill: press sw1 with {sw3,sw2} = 00, 01, 10, 11 in sequence, releasing between presses:
  - After the first press: led1:0=00, count=1, led6=0.
  - After the fourth press: count=4 (led4:2=100), led7=1.
- Overflow: fifth press with data 11 -> count stays 4; led5=1; head still 00.
- Drain: four sw0 presses -> head shows 01, 10, 11, then empty. count=0; led6=1; led7=0; led5 stays 1.
- Read on empty: one more sw0 press -> no change. Then a simultaneous sw0/sw1 press with data 10 -> count=1, head=10.
